// File: rtl/i2_vector_loader_if.sv
// Stream-in / wide-vector-out bundle for the i2 vector loader.
// master: beat source plus vector consumer; slave: the loader itself.
interface i2_vector_loader_if #(
   parameter int unsigned VEC_W = 201,
   parameter int unsigned IN_W  = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [VEC_W-1:0] out_vec;
   logic             err_len;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_vec, err_len
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_vec, err_len
   );
endinterface

// File: rtl/i2_vector_loader.sv
// Assembles a VEC_W-bit i2 input vector from framed IN_W-bit beats and holds it for the evaluator.
// Optional delivered-frame counter port frame_cnt enabled by `define LOADER_FRAME_CNT_EN.
module i2_vector_loader #(
   parameter int unsigned VEC_W = 201,
   parameter int unsigned IN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
`ifdef LOADER_FRAME_CNT_EN
   output logic [15:0]       frame_cnt,
`endif
   i2_vector_loader_if.slave ld_io
);
   localparam int unsigned NBEATS = (VEC_W + IN_W - 1) / IN_W;
   localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [CNT_W-1:0] LastBeat = CNT_W'(NBEATS - 1);

   typedef enum logic [1:0] {StFill, StDrain, StFull} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [VEC_W-1:0] beat_mask, beat_rep;
   logic             in_ready_q, out_valid_q, err_len_q;
   logic             accept;
   logic             deliver;

   assign accept  = ld_io.in_valid & in_ready_q;
   assign deliver = out_valid_q & ld_io.out_ready;

   // Beat replicated across the vector; the mask picks the current slice, bits past VEC_W drop.
   assign beat_rep = VEC_W'({NBEATS{ld_io.in_data}});

   always_comb begin
      beat_mask = '0;
      for (int unsigned i = 0; i < VEC_W; i++) begin
         beat_mask[i] = ((i / IN_W) == 32'(beat_cnt_q));
      end
      vec_d = (vec_q & ~beat_mask) | (beat_rep & beat_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFill;
         beat_cnt_q  <= '0;
         vec_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         err_len_q <= 1'b0;
         case (state_q)
            StFill: begin
               if (accept) begin
                  vec_q <= vec_d;
                  if (beat_cnt_q == LastBeat) begin
                     beat_cnt_q <= '0;
                     if (ld_io.in_last) begin
                        state_q     <= StFull;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                     end else begin
                        state_q   <= StDrain;
                        err_len_q <= 1'b1;
                     end
                  end else if (ld_io.in_last) begin
                     beat_cnt_q <= '0;
                     err_len_q  <= 1'b1;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            StDrain: begin
               // Overlong frame: swallow beats up to and including its in_last.
               if (accept && ld_io.in_last) begin
                  state_q <= StFill;
               end
            end
            StFull: begin
               if (ld_io.out_ready) begin
                  state_q     <= StFill;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= StFill;
               beat_cnt_q  <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ld_io.in_ready  = in_ready_q;
   assign ld_io.out_valid = out_valid_q;
   assign ld_io.out_vec   = vec_q;
   assign ld_io.err_len   = err_len_q;

`ifdef LOADER_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (deliver && (frame_cnt_q != 16'hFFFF)) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   logic unused_deliver;
   assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_i2_vector_loader.sv
// Randomized self-checking bench for i2_vector_loader against a frame-level reference model.
module tb_i2_vector_loader;
   localparam int unsigned VEC_W  = 201;
   localparam int unsigned IN_W   = 8;
   localparam int unsigned NBEATS = 26;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   i2_vector_loader_if #(.VEC_W(VEC_W), .IN_W(IN_W)) bus ();

`ifdef LOADER_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   i2_vector_loader #(.VEC_W(VEC_W), .IN_W(IN_W)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef LOADER_FRAME_CNT_EN
      .frame_cnt (frame_cnt),
`endif
      .ld_io     (bus)
   );

   int               n_cmp = 0;
   int               n_bad = 0;
   int               err_seen = 0;
   int               stray_valid = 0;
   int               delivered = 0;
   bit               holding = 1'b0;
   logic [VEC_W-1:0] vec_exp;

   task automatic check(input string tag, input logic [VEC_W-1:0] got,
                        input logic [VEC_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock; observe on the falling edge, clear of the sampling edge.
   task automatic tick();
      @(negedge clk);
      if (bus.err_len === 1'b1) err_seen++;
      if (bus.out_valid === 1'b1 && !holding) stray_valid++;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) check(tag, VEC_W'(bus.in_ready), VEC_W'(1));
   endtask

   task automatic do_reset();
      holding      = 1'b0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst       = 1'b0;
      delivered = 0;
      check("rst_out_valid", VEC_W'(bus.out_valid), VEC_W'(0));
      check("rst_err_len", VEC_W'(bus.err_len), VEC_W'(0));
      check("rst_in_ready", VEC_W'(bus.in_ready), VEC_W'(1));
      check("rst_out_vec", bus.out_vec, '0);
   endtask

   // Sends n beats; in_last on the final one when with_last. A frame of exactly NBEATS
   // beats ending in in_last is the only good frame; its vector is beat k at bits k*IN_W.
   task automatic send_beats(input int n, input bit with_last, input bit use_fixed,
                             input logic [IN_W-1:0] fixed, input bit idles);
      logic [IN_W-1:0] beats [64];
      logic [IN_W-1:0] b;
      bit good;
      good = with_last && (n == NBEATS);
      for (int k = 0; k < n; k++) beats[k] = use_fixed ? fixed : IN_W'($urandom);
      if (good) begin
         for (int i = 0; i < VEC_W; i++) begin
            b = beats[i / IN_W];
            vec_exp[i] = b[i % IN_W];
         end
      end
      for (int k = 0; k < n; k++) begin
         if (idles) begin
            repeat ($urandom_range(0, 2)) begin
               bus.in_valid  = 1'b0;
               bus.in_data   = IN_W'($urandom);
               bus.out_ready = 1'($urandom);
               tick();
            end
         end
         wait_ready("ready_timeout");
         bus.in_valid  = 1'b1;
         bus.in_data   = beats[k];
         bus.in_last   = with_last && (k == n - 1);
         bus.out_ready = (k == n - 1) ? 1'b0 : 1'($urandom);
         if (k == n - 1) holding = good;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic finish_good(input int hold, input int err0);
      check("valid_latency", VEC_W'(bus.out_valid), VEC_W'(1));
      check("in_ready_full", VEC_W'(bus.in_ready), VEC_W'(0));
      check("vec", bus.out_vec, vec_exp);
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'($urandom);
         bus.in_data  = IN_W'($urandom);
         bus.in_last  = 1'($urandom);
         tick();
         check("vec_hold", bus.out_vec, vec_exp);
         check("valid_hold", VEC_W'(bus.out_valid), VEC_W'(1));
         check("in_ready_hold", VEC_W'(bus.in_ready), VEC_W'(0));
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      holding       = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      delivered++;
      check("valid_drop", VEC_W'(bus.out_valid), VEC_W'(0));
      check("in_ready_after", VEC_W'(bus.in_ready), VEC_W'(1));
      check("good_no_err", VEC_W'(err_seen - err0), VEC_W'(0));
`ifdef LOADER_FRAME_CNT_EN
      check("frame_cnt", VEC_W'(frame_cnt), VEC_W'(delivered));
`endif
   endtask

   task automatic finish_bad(input int err0);
      tick();
      check("bad_err_once", VEC_W'(err_seen - err0), VEC_W'(1));
      check("bad_err_low", VEC_W'(bus.err_len), VEC_W'(0));
      check("bad_no_valid", VEC_W'(bus.out_valid), VEC_W'(0));
      check("bad_in_ready", VEC_W'(bus.in_ready), VEC_W'(1));
   endtask

   task automatic run_frame(input int n, input int hold, input bit idles);
      int e0;
      e0 = err_seen;
      send_beats(n, 1'b1, 1'b0, '0, idles);
      if (n == NBEATS) finish_good(hold, e0);
      else finish_bad(e0);
   endtask

   initial begin
      logic [VEC_W-1:0] a5_vec;
      int e0;
      int len;
      int r;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      do_reset();

      // All-A5 frame: top beat contributes only its bit 0.
      a5_vec = {1'b1, {25{8'hA5}}};
      e0 = err_seen;
      send_beats(NBEATS, 1'b1, 1'b1, 8'hA5, 1'b0);
      check("a5_vec", bus.out_vec, a5_vec);
      finish_good(10, e0);

      run_frame(5, 0, 1'b0);
      run_frame(NBEATS, 2, 1'b0);
      run_frame(30, 0, 1'b0);
      run_frame(NBEATS, 3, 1'b1);

      // Reset mid-frame, then reset while a vector is pending.
      send_beats(13, 1'b0, 1'b0, '0, 1'b0);
      do_reset();
      run_frame(NBEATS, 1, 1'b0);
      e0 = err_seen;
      send_beats(NBEATS, 1'b1, 1'b0, '0, 1'b0);
      check("pre_rst_valid", VEC_W'(bus.out_valid), VEC_W'(1));
      do_reset();
      run_frame(NBEATS, 0, 1'b1);

      for (int f = 0; f < 40; f++) begin
         r = $urandom_range(0, 9);
         if (r < 6) len = NBEATS;
         else if (r < 8) len = $urandom_range(1, NBEATS - 1);
         else len = $urandom_range(NBEATS + 1, NBEATS + 8);
         run_frame(len, $urandom_range(0, 4), 1'($urandom));
      end

`ifdef LOADER_FRAME_CNT_EN
      do_reset();
      run_frame(NBEATS, 0, 1'b0);
      run_frame(NBEATS, 1, 1'b1);
      run_frame(3, 0, 1'b0);
      run_frame(NBEATS, 0, 1'b0);
      tick();
      check("frame_cnt_three", VEC_W'(frame_cnt), VEC_W'(3));
`endif

      check("stray_valid", VEC_W'(stray_valid), VEC_W'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
